ext_sram_ctrl: RTL and testbench
================================

// Module: ext_sram_ctrl
// PURPOSE
// - Parametrised data-memory controller between the core LSU and an external async SRAM of width MEM_DW.
// - Splits 8/16/32/64-bit core accesses into little-endian SRAM beats with byte enables.
// - Inserts configurable wait states and returns sign- or zero-extended read data.
// - Uses a valid/ready request and one-cycle response handshake.
// - Decodes the address window and flags misaligned or out-of-range requests.
// PARAMETERS
// MEM_DW       16            external data width in bits: 8, 16 or 32; MB = MEM_DW/8 bytes
// MEM_AW       19            external word-address width
// BASE_ADDR    64'h8000_0000 byte address of SRAM word 0
// WAIT_CYCLES  0             extra strobe cycles per beat, 0..15
// PORTS
// clk          in   1        clock
// rst          in   1        reset; asynchronous, active-high
// req_valid    in   1        request valid
// req_ready    out  1        controller idle; request accepted on req_valid && req_ready
// req_we       in   1        1 = write, 0 = read
// req_size     in   2        0 = byte, 1 = half, 2 = word, 3 = dword
// req_unsigned in   1        1 = zero-extend read data, 0 = sign-extend
// req_addr     in   64       byte address
// req_wdata    in   64       write data, LSB-justified
// resp_valid   out  1        one-cycle completion pulse
// resp_err     out  1        request rejected; qualified by resp_valid
// resp_rdata   out  64       extended read data; qualified by resp_valid; 0 for writes and errors
// sram_data    inout MEM_DW  bidirectional SRAM data bus
// sram_addr    out  MEM_AW   SRAM word address
// sram_be      out  MEM_DW/8 byte-lane enables
// sram_we      out  1        write strobe, active-high
// sram_oe      out  1        output enable, active-high
// BEHAVIOUR
// - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, sram_we=0, sram_oe=0, sram_be=0, sram_addr=0, sram_data=Z.
// - req_ready = (state==IDLE). All other outputs are registered.
// - On acceptance, latch addr, wdata, size, we and unsigned; req_* inputs are then don't-care.
// - Error checks:
//   - Misaligned: addr not a multiple of 2^size. Out of range: addr<BASE_ADDR or addr>=BASE_ADDR+MB*2^MEM_AW.
//   - On error, go to RESP with no SRAM activity; resp_err=1 in the cycle after acceptance.
// - Beat count N = max(1, 2^size/MB). Beat k uses sram_addr = (addr-BASE_ADDR)/MB + k.
// - Beat k carries bytes addr+k*MB .. addr+k*MB+MB-1.
// - Sub-width access (2^size<MB): single beat; sram_be sets only the lanes of addr%MB .. addr%MB+2^size-1; otherwise sram_be is all ones.
// - FSM is IDLE -> SETUP -> STROBE -> (SETUP of next beat | RESP) -> IDLE. ERR requests go IDLE -> RESP.
// - SETUP (1 cycle): sram_addr/sram_be valid; on writes sram_data is driven; we=oe=0.
// - STROBE (WAIT_CYCLES+1 cycles, counted by a wait counter): we=1 on writes, oe=1 on reads.
//   - Reads sample sram_data on the last STROBE cycle into the beat's lanes of a 64-bit assembly register.
// - sram_data is driven only in SETUP/STROBE of writes; Z otherwise, including RESP.
// - RESP (1 cycle): resp_valid=1; resp_rdata is extended from bit 8*2^size-1.
// - Latency: with acceptance at cycle 0, resp_valid is high in cycle N*(WAIT_CYCLES+2)+1; error requests respond in cycle 1.
// - Beat counter width is clog2(8/MB)+1; no wrap inside a request because of the alignment rule.
// - Reset mid-operation: outputs return to reset values immediately (async); sram_we falls without waiting for an edge; the request is dropped and no resp_valid is issued.
// - resp_valid is not backpressured; the LSU must accept it.
// STRUCTURE
// - Package mem_ctrl_pkg: mem_size_t enum (BYTE/HALF/WORD/DWORD); sram_state_t enum (IDLE/SETUP/STROBE/RESP); function size_bytes().
// - Sub-module ext_sram_lane: combinational lane select (write data/be per beat) plus read sign/zero extension.
// - The FSM, counters and address decode stay in ext_sram_ctrl.
// TESTING (defaults unless noted; bench models the SRAM with byte enables)
// - sd 0x1122334455667788 @0x8000_0010:
//   - Beats sram_addr 8,9,10,11 carry 0x7788,0x5566,0x3344,0x1122 with be=2'b11.
//   - we high 1 cycle per beat; resp_valid in cycle 9, resp_err=0.
// - ld @0x8000_0010 after the above -> 4 oe beats; resp_rdata=0x1122334455667788 in cycle 9.
// - sh 0x80F0 @0x8000_0020, then lb @0x8000_0021:
//   - lb uses be=2'b10 and returns 0xFFFF_FFFF_FFFF_FF80.
//   - lbu returns 0x80; lb @0x8000_0020 returns 0xFFFF_FFFF_FFFF_FFF0.
// - Rejected requests (resp_err=1, resp_valid in cycle 1, sram_we/oe never high):
//   - lw @0x8000_0002 (misaligned).
//   - ld @0x7FFF_FFF8 (below window).
//   - lb @0x8010_0000 (above window).
// - WAIT_CYCLES=2, sw 0xDEADBEEF @0x8000_0004: beats addr 2,3 data 0xBEEF,0xDEAD; we high 3 cycles each; resp_valid in cycle 9.
// - rst pulsed during beat 2 of an sd: sram_we/oe drop before the next edge, sram_data goes Z; no resp_valid; req_ready=1 after release; next ld completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the external SRAM data-memory controller:
// access sizes, controller states and a byte-count helper.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      RESP   = 2'd3
   } sram_state_t;

   function automatic logic [3:0] size_bytes(mem_size_t s);
      return 4'd1 << s;
   endfunction

endpackage

// File: rtl/ext_sram_lane.sv
// Per-beat lane steering for writes (data and byte enables) and
// sign/zero extension of assembled read data.
module ext_sram_lane
   import mem_ctrl_pkg::*;
#(
   parameter int MEM_DW = 16
) (
   input  logic [63:0]         wdata_i,
   input  mem_size_t           size_i,
   input  logic [2:0]          byte_off_i,
   input  logic [2:0]          beat_i,
   output logic [MEM_DW-1:0]   beat_wdata_o,
   output logic [MEM_DW/8-1:0] beat_be_o,
   input  logic [63:0]         rdata_raw_i,
   input  mem_size_t           rsize_i,
   input  logic                runsigned_i,
   output logic [63:0]         rdata_ext_o
);

   localparam int MB = MEM_DW / 8;
   localparam logic [3:0] MB4 = 4'(MB);

   logic [63:0] shifted;
   logic [7:0]  be_wide;

   // Narrow accesses sit at their byte offset inside one bus word; wide ones
   // are cut into consecutive bus-width slices, one per beat.
   always_comb begin
      shifted = '0;
      be_wide = '0;
      if (size_bytes(size_i) < MB4) begin
         shifted = wdata_i << {byte_off_i, 3'b000};
         be_wide = ((8'd1 << size_bytes(size_i)) - 8'd1) << byte_off_i;
      end else begin
         shifted = wdata_i >> (6'(beat_i) * 6'(MEM_DW));
         be_wide = 8'hFF;
      end
   end

   assign beat_wdata_o = shifted[MEM_DW-1:0];
   assign beat_be_o    = be_wide[MB-1:0];

   always_comb begin
      rdata_ext_o = rdata_raw_i;
      case (rsize_i)
         BYTE:  rdata_ext_o = {{56{~runsigned_i & rdata_raw_i[7]}},  rdata_raw_i[7:0]};
         HALF:  rdata_ext_o = {{48{~runsigned_i & rdata_raw_i[15]}}, rdata_raw_i[15:0]};
         WORD:  rdata_ext_o = {{32{~runsigned_i & rdata_raw_i[31]}}, rdata_raw_i[31:0]};
         DWORD: rdata_ext_o = rdata_raw_i;
         default: rdata_ext_o = rdata_raw_i;
      endcase
   end

endmodule

// File: rtl/ext_sram_ctrl.sv
// Data-memory controller: turns LSU valid/ready requests into little-endian
// beats on an external async SRAM, with wait states and a one-cycle response.
module ext_sram_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          MEM_DW      = 16,
   parameter int          MEM_AW      = 19,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_unsigned_i,
   input  logic [63:0]         req_addr_i,
   input  logic [63:0]         req_wdata_i,
   output logic                resp_valid_o,
   output logic                resp_err_o,
   output logic [63:0]         resp_rdata_o,
   inout  wire  [MEM_DW-1:0]   sram_data_io,
   output logic [MEM_AW-1:0]   sram_addr_o,
   output logic [MEM_DW/8-1:0] sram_be_o,
   output logic                sram_we_o,
   output logic                sram_oe_o
);

   localparam int MB     = MEM_DW / 8;
   localparam int MB_LOG = $clog2(MB);
   localparam int BW     = $clog2(8 / MB) + 1;
   localparam logic [3:0]  MB4       = 4'(MB);
   localparam logic [63:0] WIN_BYTES = 64'(MB) << MEM_AW;

   sram_state_t        state_q;
   logic [63:0]        addr_q;
   logic [63:0]        wdata_q;
   mem_size_t          size_q;
   logic               we_q;
   logic               uns_q;
   logic [BW-1:0]      beat_q;
   logic [BW-1:0]      last_beat_q;
   logic [3:0]         wait_q;
   logic [63:0]        asm_q;
   logic               drive_q;
   logic [MEM_DW-1:0]  sram_wdata_q;
   logic [MEM_AW-1:0]  sram_addr_q;
   logic [MB-1:0]      sram_be_q;
   logic               sram_we_q;
   logic               sram_oe_q;
   logic               resp_valid_q;
   logic               resp_err_q;
   logic [63:0]        resp_rdata_q;

   logic               idle;
   logic [63:0]        src_addr;
   mem_size_t          src_size;
   logic [63:0]        src_wdata;
   logic [BW-1:0]      beat_nxt;
   logic [63:0]        offset;
   logic [2:0]         byte_off;
   logic [MEM_AW-1:0]  word_addr_d;
   logic [3:0]         req_bytes;
   logic               req_bad;
   logic [BW-1:0]      last_beat_d;
   logic [MEM_DW-1:0]  lane_wdata;
   logic [MB-1:0]      lane_be;
   logic [63:0]        rd_bus;
   logic [63:0]        rd_mask;
   logic [63:0]        asm_d;
   logic [63:0]        rdata_ext;

   assign idle = (state_q == IDLE);

   // While idle the next beat comes straight from the request inputs so that
   // SETUP can present a valid address in the very cycle after acceptance.
   assign src_addr  = idle ? req_addr_i : addr_q;
   assign src_size  = idle ? mem_size_t'(req_size_i) : size_q;
   assign src_wdata = idle ? req_wdata_i : wdata_q;
   assign beat_nxt  = idle ? '0 : beat_q + 1'b1;

   assign offset      = src_addr - BASE_ADDR;
   assign byte_off    = 3'(src_addr) & 3'(MB - 1);
   assign word_addr_d = MEM_AW'(offset >> MB_LOG) + MEM_AW'(beat_nxt);

   assign req_bytes   = size_bytes(mem_size_t'(req_size_i));
   assign req_bad     = ((req_addr_i[3:0] & (req_bytes - 4'd1)) != 4'd0) ||
                        (req_addr_i < BASE_ADDR) ||
                        ((req_addr_i - BASE_ADDR) >= WIN_BYTES);
   assign last_beat_d = (req_bytes > MB4) ? BW'((req_bytes >> MB_LOG) - 4'd1) : '0;

   assign rd_bus  = 64'(sram_data_io);
   assign rd_mask = 64'({MEM_DW{1'b1}}) << (6'(beat_q) * 6'(MEM_DW));

   // Read assembly: narrow reads are right-justified, wide reads fill the
   // lanes belonging to the current beat.
   always_comb begin
      asm_d = asm_q;
      if (size_bytes(size_q) < MB4) begin
         asm_d = rd_bus >> {byte_off, 3'b000};
      end else begin
         asm_d = (asm_q & ~rd_mask) | (rd_bus << (6'(beat_q) * 6'(MEM_DW)));
      end
   end

   ext_sram_lane #(.MEM_DW(MEM_DW)) u_lane (
      .wdata_i      (src_wdata),
      .size_i       (src_size),
      .byte_off_i   (byte_off),
      .beat_i       (3'(beat_nxt)),
      .beat_wdata_o (lane_wdata),
      .beat_be_o    (lane_be),
      .rdata_raw_i  (asm_d),
      .rsize_i      (size_q),
      .runsigned_i  (uns_q),
      .rdata_ext_o  (rdata_ext)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= BYTE;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         beat_q       <= '0;
         last_beat_q  <= '0;
         wait_q       <= '0;
         asm_q        <= '0;
         drive_q      <= 1'b0;
         sram_wdata_q <= '0;
         sram_addr_q  <= '0;
         sram_be_q    <= '0;
         sram_we_q    <= 1'b0;
         sram_oe_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  size_q      <= mem_size_t'(req_size_i);
                  we_q        <= req_we_i;
                  uns_q       <= req_unsigned_i;
                  beat_q      <= '0;
                  last_beat_q <= last_beat_d;
                  if (req_bad) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q      <= SETUP;
                     sram_addr_q  <= word_addr_d;
                     sram_be_q    <= lane_be;
                     sram_wdata_q <= lane_wdata;
                     drive_q      <= req_we_i;
                  end
               end
            end
            SETUP: begin
               state_q   <= STROBE;
               wait_q    <= '0;
               sram_we_q <= we_q;
               sram_oe_q <= ~we_q;
            end
            STROBE: begin
               if (wait_q == 4'(WAIT_CYCLES)) begin
                  sram_we_q <= 1'b0;
                  sram_oe_q <= 1'b0;
                  asm_q     <= asm_d;
                  if (beat_q == last_beat_q) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= we_q ? '0 : rdata_ext;
                     drive_q      <= 1'b0;
                     sram_be_q    <= '0;
                  end else begin
                     state_q      <= SETUP;
                     beat_q       <= beat_nxt;
                     sram_addr_q  <= word_addr_d;
                     sram_be_q    <= lane_be;
                     sram_wdata_q <= lane_wdata;
                  end
               end else begin
                  wait_q <= wait_q + 4'd1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = idle;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;
   assign sram_addr_o  = sram_addr_q;
   assign sram_be_o    = sram_be_q;
   assign sram_we_o    = sram_we_q;
   assign sram_oe_o    = sram_oe_q;
   assign sram_data_io = drive_q ? sram_wdata_q : {MEM_DW{1'bz}};

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Bench for ext_sram_ctrl: two instances (no wait states / two wait states)
// on byte-enabled SRAM models, checked against a byte-array reference.
module tb_ext_sram_ctrl;
   import mem_ctrl_pkg::*;

   localparam logic [63:0] BASE = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;

   always #5 clk = ~clk;

   logic        ready_a, rv_a, re_a, we_a, oe_a;
   logic [63:0] rd_a;
   logic [18:0] sa_a;
   logic [1:0]  be_a;
   wire  [15:0] sd_a;
   logic        ready_b, rv_b, re_b, we_b, oe_b;
   logic [63:0] rd_b;
   logic [18:0] sa_b;
   logic [1:0]  be_b;
   wire  [15:0] sd_b;

   logic [15:0] mem_a [0:1023];
   logic [15:0] mem_b [0:1023];
   logic [7:0]  ref_mem [2][0:2047];

   assign sd_a = oe_a ? mem_a[sa_a[9:0]] : 16'bz;
   assign sd_b = oe_b ? mem_b[sa_b[9:0]] : 16'bz;

   always @(posedge clk) begin
      if (we_a) begin
         if (be_a[0]) mem_a[sa_a[9:0]][7:0]  <= sd_a[7:0];
         if (be_a[1]) mem_a[sa_a[9:0]][15:8] <= sd_a[15:8];
      end
      if (we_b) begin
         if (be_b[0]) mem_b[sa_b[9:0]][7:0]  <= sd_b[7:0];
         if (be_b[1]) mem_b[sa_b[9:0]][15:8] <= sd_b[15:8];
      end
   end

   ext_sram_ctrl #(.MEM_DW(16), .MEM_AW(19), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && !sel), .req_ready_o(ready_a),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv_a), .resp_err_o(re_a),
      .resp_rdata_o(rd_a), .sram_data_io(sd_a), .sram_addr_o(sa_a), .sram_be_o(be_a),
      .sram_we_o(we_a), .sram_oe_o(oe_a));

   ext_sram_ctrl #(.MEM_DW(16), .MEM_AW(19), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel), .req_ready_o(ready_b),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv_b), .resp_err_o(re_b),
      .resp_rdata_o(rd_b), .sram_data_io(sd_b), .sram_addr_o(sa_b), .sram_be_o(be_b),
      .sram_we_o(we_b), .sram_oe_o(oe_b));

   wire        cur_ready = sel ? ready_b : ready_a;
   wire        cur_rv    = sel ? rv_b : rv_a;
   wire        cur_re    = sel ? re_b : re_a;
   wire [63:0] cur_rd    = sel ? rd_b : rd_a;
   wire        cur_we    = sel ? we_b : we_a;
   wire        cur_oe    = sel ? oe_b : oe_a;
   wire [18:0] cur_sa    = sel ? sa_b : sa_a;
   wire [1:0]  cur_be    = sel ? be_b : be_a;
   wire [15:0] cur_sd    = sel ? sd_b : sd_a;

   typedef struct {logic [18:0] a; logic [15:0] d; logic [1:0] be;} beat_t;
   typedef struct {logic err; logic [63:0] rd; int cyc; int wec; int oec;} obs_t;
   typedef struct {logic err; logic [63:0] rd; int cyc; int nb;} exp_t;

   beat_t beats[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Reference: byte-addressed memory, size/alignment/window rules and the
   // beats*(wait+2)+1 latency; updates the byte memory on writes.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wdata);
      exp_t e;
      int sz = 1 << size;
      int w = sel ? 2 : 0;
      logic [63:0] lim = BASE + (64'd2 << 19);
      logic [63:0] off = addr - BASE;
      e.rd  = '0;
      e.err = ((addr % 64'(sz)) != 0) || (addr < BASE) || (addr >= lim);
      if (e.err) begin
         e.cyc = 1;
         e.nb  = 0;
         return e;
      end
      e.nb  = (sz > 2) ? sz / 2 : 1;
      e.cyc = e.nb * (w + 2) + 1;
      for (int i = 0; i < sz; i++) begin
         if (we) ref_mem[sel][11'(off + 64'(i))] = wdata[8*i +: 8];
         else    e.rd[8*i +: 8] = ref_mem[sel][11'(off + 64'(i))];
      end
      if (!we && !uns && sz < 8 && e.rd[8*sz-1]) e.rd = e.rd | (~64'd0 << (8*sz));
      return e;
   endfunction

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output obs_t o, output exp_t e);
      e = model(we, size, uns, addr, wdata);
      @(posedge clk);
      #1;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      beats.delete();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_size = 2'($urandom); req_we = 1'($urandom);
      o.err = 1'b0; o.rd = '0; o.cyc = 1; o.wec = 0; o.oec = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cur_we === 1'b1) begin
            o.wec++;
            beats.push_back('{cur_sa, cur_sd, cur_be});
         end
         if (cur_oe === 1'b1) begin
            o.oec++;
            beats.push_back('{cur_sa, cur_sd, cur_be});
         end
         if (cur_rv === 1'b1) begin
            o.err = cur_re;
            o.rd  = cur_rd;
            return;
         end
         o.cyc++;
      end
      o.cyc = -1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cur_ready); end
      n_checks++; if ({cur_rv, cur_re, cur_we, cur_oe} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {cur_rv, cur_re, cur_we, cur_oe}); end
      n_checks++; if ({cur_sa, cur_be} !== 21'd0) begin n_fail++; $display("FAIL reset_addr_be: got %h expected 0", {cur_sa, cur_be}); end
      n_checks++; if (cur_rd !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", cur_rd); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (cur_ready !== 1'b1 || cur_rv !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: ready %b valid %b expected 1 0", cur_ready, cur_rv); end
   endtask

   task automatic test_sd_ld();
      obs_t o; exp_t e;
      logic [63:0] v = 64'h1122334455667788;
      do_req(1'b1, 2'd3, 1'b0, BASE + 64'h10, v, o, e);
      n_checks++; if (o.cyc !== 9 || o.err !== 1'b0) begin n_fail++; $display("FAIL sd_resp: cyc %0d err %b expected 9 0", o.cyc, o.err); end
      n_checks++; if (o.wec !== 4 || beats.size() !== 4) begin n_fail++; $display("FAIL sd_we_count: got %0d expected 4", o.wec); end
      for (int k = 0; k < 4 && k < beats.size(); k++) begin
         n_checks++;
         if (beats[k].a !== 19'(8 + k) || beats[k].d !== v[16*k +: 16] || beats[k].be !== 2'b11) begin
            n_fail++;
            $display("FAIL sd_beat%0d: got a=%0d d=%h be=%b expected a=%0d d=%h be=11", k, beats[k].a, beats[k].d, beats[k].be, 8 + k, v[16*k +: 16]);
         end
      end
      do_req(1'b0, 2'd3, 1'b0, BASE + 64'h10, '0, o, e);
      n_checks++; if (o.cyc !== 9 || o.oec !== 4) begin n_fail++; $display("FAIL ld_timing: cyc %0d oe %0d expected 9 4", o.cyc, o.oec); end
      n_checks++; if (o.rd !== v) begin n_fail++; $display("FAIL ld_data: got %h expected %h", o.rd, v); end
   endtask

   task automatic test_sub_word();
      obs_t o; exp_t e;
      do_req(1'b1, 2'd1, 1'b0, BASE + 64'h20, 64'h80F0, o, e);
      n_checks++; if (o.cyc !== 3 || o.wec !== 1) begin n_fail++; $display("FAIL sh_timing: cyc %0d we %0d expected 3 1", o.cyc, o.wec); end
      do_req(1'b0, 2'd0, 1'b0, BASE + 64'h21, '0, o, e);
      n_checks++; if (beats.size() !== 1 || beats[0].be !== 2'b10) begin n_fail++; $display("FAIL lb_be: got %0d beats expected be=10", beats.size()); end
      n_checks++; if (o.rd !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_odd: got %h expected ffffffffffffff80", o.rd); end
      do_req(1'b0, 2'd0, 1'b1, BASE + 64'h21, '0, o, e);
      n_checks++; if (o.rd !== 64'h80) begin n_fail++; $display("FAIL lbu_odd: got %h expected 80", o.rd); end
      do_req(1'b0, 2'd0, 1'b0, BASE + 64'h20, '0, o, e);
      n_checks++; if (o.rd !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_fail++; $display("FAIL lb_even: got %h expected fffffffffffffff0", o.rd); end
   endtask

   task automatic test_errors();
      obs_t o; exp_t e;
      logic [63:0] addrs [3] = '{64'h8000_0002, 64'h7FFF_FFF8, 64'h8010_0000};
      logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, sizes[i], 1'b0, addrs[i], '0, o, e);
         n_checks++;
         if (o.err !== 1'b1 || o.cyc !== 1 || o.wec + o.oec !== 0 || o.rd !== 64'd0) begin
            n_fail++;
            $display("FAIL err_case%0d: err %b cyc %0d strobes %0d rd %h expected 1 1 0 0", i, o.err, o.cyc, o.wec + o.oec, o.rd);
         end
      end
   endtask

   task automatic test_wait_states();
      obs_t o; exp_t e;
      sel = 1'b1;
      do_req(1'b1, 2'd2, 1'b0, BASE + 64'h4, 64'hDEADBEEF, o, e);
      n_checks++; if (o.cyc !== 9 || o.wec !== 6 || beats.size() !== 6) begin n_fail++; $display("FAIL ws_sw_timing: cyc %0d we %0d expected 9 6", o.cyc, o.wec); end
      for (int k = 0; k < 6 && k < beats.size(); k++) begin
         n_checks++;
         if (beats[k].a !== 19'(2 + k / 3) || beats[k].d !== ((k < 3) ? 16'hBEEF : 16'hDEAD)) begin
            n_fail++;
            $display("FAIL ws_beat%0d: got a=%0d d=%h", k, beats[k].a, beats[k].d);
         end
      end
      do_req(1'b0, 2'd2, 1'b0, BASE + 64'h4, '0, o, e);
      n_checks++; if (o.rd !== 64'hFFFF_FFFF_DEAD_BEEF || o.cyc !== 9) begin n_fail++; $display("FAIL ws_lw: got %h cyc %0d expected ffffffffdeadbeef 9", o.rd, o.cyc); end
      sel = 1'b0;
   endtask

   task automatic test_reset_midop();
      obs_t o; exp_t e;
      int pulses = 0;
      do_req(1'b1, 2'd3, 1'b0, BASE + 64'h40, 64'h0102_0304_0506_0708, o, e);
      @(posedge clk);
      #1;
      req_we = 1'b1; req_size = 2'd3; req_addr = BASE + 64'h40; req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (cur_we !== 1'b1 || cur_sa !== 19'h21 || cur_ready !== 1'b0) begin n_fail++; $display("FAIL midop_beat2: we %b a %h ready %b expected 1 21 0", cur_we, cur_sa, cur_ready); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (cur_we !== 1'b0 || cur_oe !== 1'b0) begin n_fail++; $display("FAIL midop_async_drop: we %b oe %b expected 0 0", cur_we, cur_oe); end
      n_checks++; if (cur_sa !== 19'd0 || cur_be !== 2'd0 || cur_ready !== 1'b1) begin n_fail++; $display("FAIL midop_reset_vals: a %h be %b ready %b", cur_sa, cur_be, cur_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (cur_rv === 1'b1) pulses++;
      end
      n_checks++; if (pulses !== 0 || cur_ready !== 1'b1) begin n_fail++; $display("FAIL midop_no_resp: pulses %0d ready %b expected 0 1", pulses, cur_ready); end
      ref_mem[0][11'h40] = 8'hDD;
      ref_mem[0][11'h41] = 8'hDD;
      do_req(1'b0, 2'd3, 1'b0, BASE + 64'h40, '0, o, e);
      n_checks++; if (o.rd !== 64'h0102_0304_0506_DDDD || o.cyc !== 9 || o.err !== 1'b0) begin n_fail++; $display("FAIL midop_ld: got %h cyc %0d expected 010203040506dddd 9", o.rd, o.cyc); end
   endtask

   task automatic test_random();
      obs_t o; exp_t e;
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  size = 2'($urandom_range(0, 3));
         logic [63:0] off  = 64'($urandom_range(0, 2047)) & ~64'((1 << size) - 1);
         logic [63:0] addr;
         logic        we = 1'($urandom);
         int          mode = $urandom_range(0, 7);
         int          w;
         sel = 1'($urandom);
         w = sel ? 2 : 0;
         case (mode)
            0: addr = BASE + off + ((size != 0) ? 64'd1 : 64'd0);
            1: addr = BASE - 64'(8 * $urandom_range(1, 4));
            2: addr = BASE + 64'h10_0000 + off;
            default: addr = BASE + off;
         endcase
         do_req(we, size, 1'($urandom), addr, {$urandom, $urandom}, o, e);
         n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", n, o.err, e.err); end
         n_checks++; if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, o.cyc, e.cyc); end
         n_checks++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, o.rd, e.rd); end
         n_checks++;
         if (o.wec !== (we ? e.nb * (w + 1) : 0) || o.oec !== (we ? 0 : e.nb * (w + 1))) begin
            n_fail++;
            $display("FAIL rnd%0d_strobes: we %0d oe %0d beats %0d", n, o.wec, o.oec, e.nb);
         end
      end
      sel = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 2048; i++) begin
         ref_mem[0][i] = '0;
         ref_mem[1][i] = '0;
      end
      test_reset();
      test_sd_ld();
      test_sub_word();
      test_errors();
      test_wait_states();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
